// File: rtl/pipe_pkg.sv
// Shared types and encodings for the elastic pipeline stage.
package pipe_pkg;

  // The encoding matches the occupancy count, so occupancy is a plain copy of the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  function automatic logic [1:0] occ_of(input pipe_state_t s);
    logic [1:0] occ;
    case (s)
      ONE:     occ = OCC_ONE;
      TWO:     occ = OCC_TWO;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_word_reg.sv
// One stage-word register. It resets to the bubble word; clear wins over load.
module pipe_word_reg #(
  parameter int               WIDTH      = 175,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_word;

  // Word storage: clear to bubble, else optional load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        r_word <= BUBBLE_VAL;
    else if (clear) r_word <= BUBBLE_VAL;
    else if (load)  r_word <= load_val;
  end

  assign q = r_word;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register with valid/ready flow control, a
// synchronous flush, and an optional skid entry for a registered in_ready.
//
// state | meaning
// EMPTY | nothing held; out_data shows the bubble word
// ONE   | main entry holds the word on out_data
// TWO   | main and skid both full; upstream is stalled (SKID=1 only)
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 175,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}},
  parameter bit               SKID       = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_t      r_state;
  pipe_state_t      w_state_nxt;
  logic             r_out_valid;
  logic [1:0]       r_occupancy;

  logic             w_accept;
  logic             w_consume;
  logic             w_main_load;
  logic             w_main_clear;
  logic [WIDTH-1:0] w_main_val;
  logic             w_skid_load;
  logic             w_skid_clear;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_consume = r_out_valid & out_ready;

  // Next state plus the load controls and the main-entry input mux.
  always_comb begin
    w_state_nxt  = r_state;
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
    w_main_val   = in_data;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    if (flush) begin
      // A consume in this cycle has already seen the current word; drop the rest.
      w_state_nxt  = EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ONE;
            w_main_load = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_consume) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            // Without a skid entry, in_ready guarantees that an accept comes with a consume.
            if (SKID) begin
              w_state_nxt = TWO;
              w_skid_load = 1'b1;
            end
          end else if (w_consume) begin
            w_state_nxt = EMPTY;
            w_main_load = 1'b1;
            w_main_val  = BUBBLE_VAL;
          end
        end
        TWO: begin
          if (w_consume) begin
            w_state_nxt  = ONE;
            w_main_load  = 1'b1;
            w_main_val   = w_skid_q;
            w_skid_clear = 1'b1;
          end
        end
        default: begin
          w_state_nxt  = EMPTY;
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  // State register, with out_valid and occupancy registered directly from the next state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_occupancy <= OCC_EMPTY;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != EMPTY);
      r_occupancy <= occ_of(w_state_nxt);
    end
  end

  pipe_word_reg #(
    .WIDTH      (WIDTH),
    .BUBBLE_VAL (BUBBLE_VAL)
  ) u_main (
    .CLK      (CLK),
    .RST      (RST),
    .load     (w_main_load),
    .load_val (w_main_val),
    .clear    (w_main_clear),
    .q        (w_main_q)
  );

  if (SKID) begin : g_skid
    logic r_in_ready;

    pipe_word_reg #(
      .WIDTH      (WIDTH),
      .BUBBLE_VAL (BUBBLE_VAL)
    ) u_skid (
      .CLK      (CLK),
      .RST      (RST),
      .load     (w_skid_load),
      .load_val (in_data),
      .clear    (w_skid_clear),
      .q        (w_skid_q)
    );

    // Registered ready: low exactly while both entries are full.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_in_ready <= 1'b1;
      else     r_in_ready <= (w_state_nxt != TWO);
    end

    assign in_ready = r_in_ready;
  end else begin : g_no_skid
    assign w_skid_q = BUBBLE_VAL;
    assign in_ready = ~r_out_valid | out_ready;
  end

  assign out_valid = r_out_valid;
  assign out_data  = w_main_q;
  assign occupancy = r_occupancy;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: instance 0 runs with SKID=0 and instance 1 with SKID=1.
// Each instance has its own scoreboard queue, filled on accept and popped on consume.
module tb_pipe_stage_elastic;

  localparam int          W   = 16;
  localparam logic [W-1:0] BUB = 16'h5A5A;

  logic         CLK = 1'b0;
  logic         RST;
  logic         flush     [2];
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [W-1:0] in_data   [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [W-1:0] out_data  [2];
  logic [1:0]   occupancy [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  pipe_stage_elastic #(.WIDTH(W), .BUBBLE_VAL(BUB), .SKID(1'b0)) u_dut0 (
    .CLK(CLK), .RST(RST), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .occupancy(occupancy[0])
  );

  pipe_stage_elastic #(.WIDTH(W), .BUBBLE_VAL(BUB), .SKID(1'b1)) u_dut1 (
    .CLK(CLK), .RST(RST), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .occupancy(occupancy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else             n_pass++;
  endtask

  // Scoreboard and per-cycle model checks, sampled on the falling edge.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic [W-1:0] q[$];
    always @(negedge CLK) begin : mon
      logic exp_rdy;
      if (RST) begin
        q.delete();
      end else begin
        exp_rdy = (g == 1) ? (q.size() != 2) : ((q.size() == 0) || out_ready[g]);
        check($sformatf("occ%0d", g), 32'(occupancy[g]), 32'(q.size()));
        check($sformatf("valid%0d", g), 32'(out_valid[g]), 32'(q.size() != 0));
        check($sformatf("in_ready%0d", g), 32'(in_ready[g]), 32'(exp_rdy));
        if (q.size() == 0) check($sformatf("bubble%0d", g), 32'(out_data[g]), 32'(BUB));
        else               check($sformatf("head%0d", g), 32'(out_data[g]), 32'(q[0]));
        if (out_valid[g] && out_ready[g]) begin
          if (q.size() == 0) check($sformatf("underflow%0d", g), 32'd1, 32'd0);
          else               void'(q.pop_front());
        end
        if (flush[g])                         q.delete();
        else if (in_valid[g] && in_ready[g])  q.push_back(in_data[g]);
      end
    end
  end

  // Present w on instance d and return one edge after it is accepted (called at edge+1).
  task automatic send(input int d, input logic [W-1:0] w);
    bit ok;
    ok = 1'b0;
    in_valid[d] = 1'b1;
    in_data[d]  = w;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge CLK);
      if (in_ready[d]) ok = 1'b1;
      @(posedge CLK);
      #1;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    logic [W-1:0] w;
    logic [2:0]  pat;

    RST = 1'b1;
    for (int d = 0; d < 2; d++) begin
      flush[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0;
    end
    #12 RST = 1'b0;

    // Reset and idle.
    idle(5);
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", 32'(out_valid[d]), 32'd0);
      check("rst_data",  32'(out_data[d]),  32'(BUB));
      check("rst_ready", 32'(in_ready[d]),  32'd1);
      check("rst_occ",   32'(occupancy[d]), 32'd0);
    end

    // Streaming at full rate with one-cycle latency.
    for (int d = 0; d < 2; d++) begin
      out_ready[d] = 1'b1;
      c0 = cyc;
      for (int i = 1; i <= 16; i++) begin
        send(d, W'(i));
        check("lat_data",  32'(out_data[d]),  32'(i));
        check("lat_valid", 32'(out_valid[d]), 32'd1);
      end
      in_valid[d] = 1'b0;
      check("throughput", 32'(cyc - c0), 32'd16);
      idle(2);
    end

    // SKID=1 stall: two words buffered, then the third is held upstream.
    out_ready[1] = 1'b0;
    send(1, 16'h00A1);
    check("stall_occ1", 32'(occupancy[1]), 32'd1);
    send(1, 16'h00A2);
    check("stall_occ2", 32'(occupancy[1]), 32'd2);
    check("stall_rdy",  32'(in_ready[1]),  32'd0);
    in_valid[1] = 1'b1;
    in_data[1]  = 16'h00A3;
    repeat (3) begin
      idle(1);
      check("hold_rdy",  32'(in_ready[1]),  32'd0);
      check("hold_data", 32'(out_data[1]),  32'h00A1);
    end
    out_ready[1] = 1'b1;
    idle(1);
    check("drain_rdy",  32'(in_ready[1]),  32'd1);
    check("drain_occ",  32'(occupancy[1]), 32'd1);
    check("drain_data", 32'(out_data[1]),  32'h00A2);
    send(1, 16'h00A3);
    check("drain_a3", 32'(out_data[1]), 32'h00A3);
    in_valid[1] = 1'b0;
    idle(2);
    check("drain_empty", 32'(occupancy[1]), 32'd0);

    // Flush while full with a valid input word that must be dropped.
    out_ready[1] = 1'b0;
    send(1, 16'h00C1);
    send(1, 16'h00C2);
    in_valid[1] = 1'b1;
    in_data[1]  = 16'h00B7;
    flush[1]    = 1'b1;
    idle(1);
    flush[1]    = 1'b0;
    in_valid[1] = 1'b0;
    check("flush_occ",   32'(occupancy[1]), 32'd0);
    check("flush_valid", 32'(out_valid[1]), 32'd0);
    check("flush_data",  32'(out_data[1]),  32'(BUB));
    out_ready[1] = 1'b1;
    repeat (3) begin
      idle(1);
      check("no_b7", 32'(out_valid[1]), 32'd0);
    end

    // Flush coinciding with a consume on the single-entry instance.
    out_ready[0] = 1'b1;
    send(0, 16'h0041);
    in_data[0] = 16'h0042;
    flush[0]   = 1'b1;
    idle(1);
    flush[0]    = 1'b0;
    in_valid[0] = 1'b0;
    check("flush0_occ",  32'(occupancy[0]), 32'd0);
    check("flush0_data", 32'(out_data[0]),  32'(BUB));

    // SKID=0: in_ready follows out_ready within the cycle while a word is held.
    out_ready[0] = 1'b1;
    send(0, 16'h0031);
    w = 16'h0032;
    in_data[0] = w;
    pat = 3'b101;
    for (int k = 0; k < 3; k++) begin
      out_ready[0] = pat[k];
      #1;
      check("rdy_track", 32'(in_ready[0]), 32'(pat[k]));
      @(posedge CLK);
      #1;
      if (pat[k]) begin
        w = w + 16'd1;
        in_data[0] = w;
      end
    end
    in_valid[0] = 1'b0;
    idle(3);

    // Asynchronous reset between edges while holding words.
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    send(1, 16'h0061);
    send(1, 16'h0062);
    in_valid[1] = 1'b0;
    send(0, 16'h0071);
    in_valid[0] = 1'b0;
    check("pre_rst_occ", 32'(occupancy[1]), 32'd2);
    #2 RST = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("arst_valid", 32'(out_valid[d]), 32'd0);
      check("arst_data",  32'(out_data[d]),  32'(BUB));
      check("arst_occ",   32'(occupancy[d]), 32'd0);
      check("arst_ready", 32'(in_ready[d]),  32'd1);
    end
    @(negedge CLK);
    #2 RST = 1'b0;
    idle(1);
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    send(1, 16'h0063);
    check("post_rst1", 32'(out_data[1]), 32'h0063);
    in_valid[1] = 1'b0;
    send(0, 16'h0073);
    check("post_rst0", 32'(out_data[0]), 32'h0073);
    in_valid[0] = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
